// File: rtl/bsg_hash_bank_reverse_iter.sv
// Reverse bank hash: rebuilds an address from (in-bank index, bank id) as
// index*banks_p + bank, truncated to width_p, with an exact overflow flag.
// Power-of-two bank counts resolve in one cycle by concatenation. Other bank
// counts use an iterative shift-add over the bits of banks_p.
// One request is in flight at a time, with a valid/ready in and valid/yumi out.
//
// Ports:
//   clk_i      - clock, all state on the rising edge
//   reset_n_i  - asynchronous active-low reset
//   v_i        - request valid; accepted when v_i & ready_o
//   index_i    - in-bank index
//   bank_i     - bank id
//   ready_o    - idle and able to accept a request
//   v_o        - result valid
//   data_o     - reconstructed address (mod 2^width_p)
//   ovf_o      - full-precision result did not fit in width_p bits
//   err_o      - bank_i was >= banks_p
//   yumi_i     - consumer takes the result (only meaningful while v_o=1)
module bsg_hash_bank_reverse_iter #(
    parameter  int unsigned banks_p       = 3,
    parameter  int unsigned index_width_p = 8,
    parameter  int unsigned width_p       = 10,
    localparam int unsigned bank_width_lp = (banks_p > 1) ? $clog2(banks_p) : 1,
    localparam bit          pow2_lp       = ((banks_p & (banks_p - 1)) == 0)
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     v_i,
    input  logic [index_width_p-1:0] index_i,
    input  logic [bank_width_lp-1:0] bank_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     ovf_o,
    output logic                     err_o,
    input  logic                     yumi_i
);

    // Accumulator wide enough that the overflow test is exact.
    localparam int unsigned acc_width_lp = width_p + index_width_p + bank_width_lp;
    localparam int unsigned shift_lp     = (banks_p > 1) ? $clog2(banks_p) : 0;
    localparam int unsigned k_width_lp   = (bank_width_lp > 1) ? $clog2(bank_width_lp) : 1;
    localparam int unsigned sel_width_lp = 1 << k_width_lp;

    // banks_p bits, sized so the iteration counter indexes it exactly.
    localparam logic [sel_width_lp-1:0] banks_sel_lp = sel_width_lp'(banks_p);
    localparam logic [k_width_lp-1:0]   k_last_lp    = k_width_lp'(bank_width_lp - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                     r_state,  w_state_n;
    logic [index_width_p-1:0]   r_index,  w_index_n;
    logic [acc_width_lp-1:0]    r_acc,    w_acc_n;
    logic [k_width_lp-1:0]      r_k,      w_k_n;
    logic [width_p-1:0]         r_data,   w_data_n;
    logic                       r_ovf,    w_ovf_n;
    logic                       r_err,    w_err_n;
    logic                       r_v,      w_v_n;
    logic                       r_ready,  w_ready_n;

    logic                       w_accept;
    logic                       w_bank_bad;
    logic [acc_width_lp-1:0]    w_pow2_sum;
    logic [acc_width_lp-1:0]    w_term;
    logic [acc_width_lp-1:0]    w_calc_sum;

    assign w_accept   = v_i & r_ready;
    assign w_bank_bad = (32'(bank_i) >= banks_p);

    // Power-of-two case: index*banks_p + bank is a shift and add (no carries).
    assign w_pow2_sum = (acc_width_lp'(index_i) << shift_lp) + acc_width_lp'(bank_i);

    // One shift-add step: include index<<k when bit k of banks_p is set.
    assign w_term     = banks_sel_lp[r_k] ? (acc_width_lp'(r_index) << r_k) : '0;
    assign w_calc_sum = r_acc + w_term;

    // Next-state and next-output logic.
    always_comb begin
        w_state_n = r_state;
        w_index_n = r_index;
        w_acc_n   = r_acc;
        w_k_n     = r_k;
        w_data_n  = r_data;
        w_ovf_n   = r_ovf;
        w_err_n   = r_err;
        w_v_n     = r_v;
        w_ready_n = r_ready;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_index_n = index_i;
                    w_ready_n = 1'b0;
                    if (w_bank_bad) begin
                        w_state_n = ST_DONE;
                        w_acc_n   = '0;
                        w_data_n  = '0;
                        w_ovf_n   = 1'b0;
                        w_err_n   = 1'b1;
                        w_v_n     = 1'b1;
                    end else if (pow2_lp) begin
                        w_state_n = ST_DONE;
                        w_acc_n   = w_pow2_sum;
                        w_data_n  = w_pow2_sum[width_p-1:0];
                        w_ovf_n   = |w_pow2_sum[acc_width_lp-1:width_p];
                        w_err_n   = 1'b0;
                        w_v_n     = 1'b1;
                    end else begin
                        w_state_n = ST_CALC;
                        w_acc_n   = acc_width_lp'(bank_i);
                        w_k_n     = '0;
                    end
                end
            end

            ST_CALC: begin
                w_acc_n = w_calc_sum;
                w_k_n   = r_k + k_width_lp'(1);
                if (r_k == k_last_lp) begin
                    w_state_n = ST_DONE;
                    w_data_n  = w_calc_sum[width_p-1:0];
                    w_ovf_n   = |w_calc_sum[acc_width_lp-1:width_p];
                    w_err_n   = 1'b0;
                    w_v_n     = 1'b1;
                end
            end

            ST_DONE: begin
                // Result held until taken; return to idle without accepting this cycle.
                if (yumi_i) begin
                    w_state_n = ST_IDLE;
                    w_acc_n   = '0;
                    w_k_n     = '0;
                    w_data_n  = '0;
                    w_ovf_n   = 1'b0;
                    w_err_n   = 1'b0;
                    w_v_n     = 1'b0;
                    w_ready_n = 1'b1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
                w_acc_n   = '0;
                w_k_n     = '0;
                w_data_n  = '0;
                w_ovf_n   = 1'b0;
                w_err_n   = 1'b0;
                w_v_n     = 1'b0;
                w_ready_n = 1'b1;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_acc   <= '0;
            r_k     <= '0;
            r_data  <= '0;
            r_ovf   <= 1'b0;
            r_err   <= 1'b0;
            r_v     <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_n;
            r_index <= w_index_n;
            r_acc   <= w_acc_n;
            r_k     <= w_k_n;
            r_data  <= w_data_n;
            r_ovf   <= w_ovf_n;
            r_err   <= w_err_n;
            r_v     <= w_v_n;
            r_ready <= w_ready_n;
        end
    end

    assign ready_o = r_ready;
    assign v_o     = r_v;
    assign data_o  = r_data;
    assign ovf_o   = r_ovf;
    assign err_o   = r_err;

endmodule

// File: tb/tb_bsg_hash_bank_reverse_iter.sv
// Scoreboard bench for bsg_hash_bank_reverse_iter. Three instances:
//   dut0: banks_p=3 width_p=10 (iterative path, bank 3 is an error)
//   dut1: banks_p=4 width_p=10 (power-of-two path)
//   dut2: banks_p=3 width_p=8  (iterative path with overflow)
// Drivers push the expected result and its due cycle on acceptance; one monitor
// compares every cycle, drives yumi_i, and checks idle/backpressure behaviour.
module tb_bsg_hash_bank_reverse_iter;

    typedef struct packed {
        int          due;
        logic [9:0]  data;
        logic        ovf;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    logic       v_a[3];
    logic [7:0] idx_a[3];
    logic [1:0] bk_a[3];
    logic       yumi_a[3];

    logic       rdy0, rdy1, rdy2;
    logic       vo0, vo1, vo2;
    logic       ovf0, ovf1, ovf2;
    logic       err0, err1, err2;
    logic [9:0] dat0, dat1;
    logic [7:0] dat2;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    logic seen[3];
    logic yumi_prev[3];
    int   hold[3];

    bsg_hash_bank_reverse_iter #(.banks_p(3), .index_width_p(8), .width_p(10)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a[0]), .index_i(idx_a[0]), .bank_i(bk_a[0]),
        .ready_o(rdy0), .v_o(vo0), .data_o(dat0), .ovf_o(ovf0), .err_o(err0), .yumi_i(yumi_a[0]));

    bsg_hash_bank_reverse_iter #(.banks_p(4), .index_width_p(8), .width_p(10)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a[1]), .index_i(idx_a[1]), .bank_i(bk_a[1]),
        .ready_o(rdy1), .v_o(vo1), .data_o(dat1), .ovf_o(ovf1), .err_o(err1), .yumi_i(yumi_a[1]));

    bsg_hash_bank_reverse_iter #(.banks_p(3), .index_width_p(8), .width_p(8)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_a[2]), .index_i(idx_a[2]), .bank_i(bk_a[2]),
        .ready_o(rdy2), .v_o(vo2), .data_o(dat2), .ovf_o(ovf2), .err_o(err2), .yumi_i(yumi_a[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cyc);
        $fatal(1);
    end

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Reference: address = index*banks + bank, reduced mod 2^width.
    function automatic exp_t model(input int d, input int idx, input int bk);
        exp_t e;
        int   nb;
        int   w;
        int   bw;
        int   full;
        nb = (d == 1) ? 4 : 3;
        w  = (d == 2) ? 8 : 10;
        bw = 0;
        while ((1 << bw) < nb) bw++;
        if (bw == 0) bw = 1;
        e = '0;
        if (bk >= nb) begin
            e.err = 1'b1;
            e.due = 1;
        end else begin
            full   = idx * nb + bk;
            e.data = 10'(full % (1 << w));
            e.ovf  = (full >= (1 << w));
            e.due  = ((nb & (nb - 1)) == 0) ? 1 : bw + 1;
        end
        return e;
    endfunction

    function automatic logic get_rdy(input int d);
        case (d)
            0:       return rdy0;
            1:       return rdy1;
            default: return rdy2;
        endcase
    endfunction

    task automatic get_out(input int d, output logic v, output logic r, output logic [9:0] dt,
                           output logic o, output logic e);
        case (d)
            0:       begin v = vo0; r = rdy0; dt = dat0;          o = ovf0; e = err0; end
            1:       begin v = vo1; r = rdy1; dt = dat1;          o = ovf1; e = err1; end
            default: begin v = vo2; r = rdy2; dt = {2'b00, dat2}; o = ovf2; e = err2; end
        endcase
    endtask

    function automatic int q_size(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t q_front(input int d);
        case (d)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic q_pop(input int d);
        case (d)
            0:       q0.delete(0);
            1:       q1.delete(0);
            default: q2.delete(0);
        endcase
    endtask

    task automatic q_push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Present one request from a falling edge; record the expectation once accepted.
    task automatic send(input int d, input logic [7:0] idx, input logic [1:0] bk);
        exp_t e;
        int   n;
        n = 0;
        v_a[d]   = 1'b1;
        idx_a[d] = idx;
        bk_a[d]  = bk;
        while (!get_rdy(d)) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                chk("accept_timeout", d, 64'(0), 64'(1));
                v_a[d] = 1'b0;
                return;
            end
        end
        e     = model(d, int'(idx), int'(bk));
        e.due = cyc + e.due;
        q_push(d, e);
        @(negedge clk);
        v_a[d] = 1'b0;
    endtask

    // Drive junk requests while the DUT is busy; none may be accepted.
    task automatic poke(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            if (get_rdy(d)) break;
            v_a[d]   = 1'b1;
            idx_a[d] = 8'($urandom);
            bk_a[d]  = 2'($urandom);
            @(negedge clk);
        end
        v_a[d] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((q0.size() + q1.size() + q2.size()) != 0 || !(rdy0 && rdy1 && rdy2)) begin
            @(negedge clk);
            n++;
            if (n > 500) begin
                chk("drain_timeout", 0, 64'(0), 64'(1));
                break;
            end
        end
    endtask

    task automatic rand_drv(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d, 8'($urandom), 2'($urandom));
        end
    endtask

    task automatic mon_one(input int d);
        logic       v;
        logic       r;
        logic       o;
        logic       e;
        logic [9:0] dt;
        exp_t       f;
        get_out(d, v, r, dt, o, e);
        if (yumi_prev[d]) chk("ready_after_yumi", d, 64'({v, r}), 64'(2'b01));
        yumi_prev[d] = 1'b0;
        if (v) begin
            chk("busy_ready", d, 64'(r), 64'(0));
            if (q_size(d) == 0) begin
                chk("unexpected_v_o", d, 64'(1), 64'(0));
                yumi_a[d] = 1'b1;
            end else begin
                f = q_front(d);
                if (!seen[d]) begin
                    chk("latency", d, 64'(cyc), 64'(f.due));
                    seen[d] = 1'b1;
                end
                chk("result", d, 64'({dt, o, e}), 64'({f.data, f.ovf, f.err}));
                if (hold[d] > 0) begin
                    hold[d]--;
                    yumi_a[d] = 1'b0;
                end else begin
                    yumi_a[d] = 1'($urandom_range(0, 1));
                end
                if (yumi_a[d]) begin
                    q_pop(d);
                    seen[d]      = 1'b0;
                    yumi_prev[d] = 1'b1;
                end
            end
        end else begin
            chk("idle_zero", d, 64'({dt, o, e}), 64'(0));
            if (q_size(d) != 0) begin
                f = q_front(d);
                if (cyc >= f.due) begin
                    chk("v_o_missing", d, 64'(0), 64'(1));
                    q_pop(d);
                end
            end
            // Stray yumi while nothing is valid must be ignored.
            yumi_a[d] = ($urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int d = 0; d < 3; d++) mon_one(d);
            end
        end
    end

    initial begin
        int         dd[10];
        int         di[10];
        int         db[10];
        logic       v;
        logic       r;
        logic       o;
        logic       e;
        logic [9:0] dt;

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            v_a[d] = 1'b0; idx_a[d] = '0; bk_a[d] = '0; yumi_a[d] = 1'b0;
            seen[d] = 1'b0; yumi_prev[d] = 1'b0; hold[d] = 0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            get_out(d, v, r, dt, o, e);
            chk("reset_ready", d, 64'(r), 64'(1));
            chk("reset_outputs", d, 64'({v, dt, o, e}), 64'(0));
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases: named examples plus range edges.
        dd = '{0,   1,   2,   0,   2,   2,   1,   0,   0,   2};
        di = '{5,   42,  100, 9,   85,  85,  255, 255, 0,   255};
        db = '{2,   3,   2,   3,   1,   0,   3,   2,   0,   3};
        for (int i = 0; i < 10; i++) begin
            send(dd[i], 8'(di[i]), 2'(db[i]));
            wait_idle();
        end

        // Backpressure: hold result five cycles and offer ignored requests.
        hold[0] = 5;
        send(0, 8'd77, 2'd1);
        poke(0, 12);
        wait_idle();

        // Reset in the middle of an iterative calculation.
        send(0, 8'd5, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        get_out(0, v, r, dt, o, e);
        chk("abort_ready", 0, 64'(r), 64'(1));
        chk("abort_outputs", 0, 64'({v, dt, o, e}), 64'(0));
        q0.delete();
        q1.delete();
        q2.delete();
        for (int d = 0; d < 3; d++) begin
            seen[d] = 1'b0; yumi_prev[d] = 1'b0; hold[d] = 0;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 8'd5, 2'd2);
        wait_idle();

        // Random concurrent traffic on all three instances.
        fork
            rand_drv(0, 40);
            rand_drv(1, 40);
            rand_drv(2, 40);
        join
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsg_hash_bank_reverse_iter.md
BSG_HASH_BANK_REVERSE_ITER -- requirements
Module: bsg_hash_bank_reverse_iter

Interface
REQ-001 SHALL have parameter banks_p, default 3: number of banks, >=1, any integer (not only powers of two).
REQ-002 SHALL have parameter index_width_p, default 8: width of the per-bank index.
REQ-003 SHALL have parameter width_p, default 10: width of the reconstructed address.
REQ-004 SHALL define localparam bank_width_lp = max(1, clog2(banks_p)) and pow2_lp = (banks_p is a power of two).
REQ-005 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-006 SHALL have port reset_n_i  input  1  reset, asynchronous assert, active-low, one clock domain.
REQ-007 SHALL have port v_i  input  1  request valid.
REQ-008 SHALL have port index_i  input  index_width_p  in-bank index.
REQ-009 SHALL have port bank_i  input  bank_width_lp  bank id.
REQ-010 SHALL have port ready_o  output  1  request accepted when v_i & ready_o.
REQ-011 SHALL have port v_o  output  1  result valid.
REQ-012 SHALL have port data_o  output  width_p  reconstructed address.
REQ-013 SHALL have port ovf_o  output  1  full-precision result did not fit width_p.
REQ-014 SHALL have port err_o  output  1  bank_i >= banks_p.
REQ-015 SHALL have port yumi_i  input  1  consumer takes result; legal only while v_o=1.

Function
REQ-016 SHALL compute data_o = (index_i*banks_p + bank_i) mod 2^width_p; ovf_o=1 iff the unreduced value >= 2^width_p.
REQ-017 SHALL implement FSM states IDLE, CALC, DONE; ready_o=1 only in IDLE; v_o=1 only in DONE.
REQ-018 SHALL, in IDLE on v_i&ready_o, register index_i and bank_i; v_i without ready_o is ignored.
REQ-019 SHALL, on acceptance with bank_i >= banks_p, go to DONE with data_o=0, ovf_o=0, err_o=1.
REQ-020 SHALL, when pow2_lp, go IDLE->DONE with data_o = {index,bank} (only the low clog2(banks_p) bank bits; banks_p=1 gives data_o=index), truncated/zero-extended to width_p; latency 1 cycle.
REQ-021 SHALL, when not pow2_lp, go IDLE->CALC with acc=bank, k=0; each CALC cycle add (index<<k) to acc if banks_p bit k is set, then k++; leave CALC to DONE after k=bank_width_lp-1.
REQ-022 SHALL keep acc at width_p+index_width_p+bank_width_lp bits so ovf_o is exact.
REQ-023 SHALL give non-pow2 latency exactly bank_width_lp+1 cycles from acceptance edge to v_o=1.
REQ-024 SHALL hold data_o, ovf_o, err_o stable while v_o=1 and yumi_i=0.
REQ-025 SHALL, in DONE on yumi_i, return to IDLE (ready_o=1 next cycle); no new request accepted in the same cycle (one request in flight).
REQ-026 SHALL ignore yumi_i when v_o=0; data_o/ovf_o/err_o SHALL be 0 when v_o=0.

Reset
REQ-027 SHALL, on reset_n_i=0 asynchronously, force IDLE, v_o=0, ready_o=1, data_o=0, ovf_o=0, err_o=0, acc=0, k=0.
REQ-028 SHALL abort any in-flight CALC/DONE on reset with no result emitted; first request after reset deassertion behaves as from power-up.

Verification
REQ-029 SHALL check banks_p=3, width_p=10: index=5, bank=2 -> v_o=1 three cycles after acceptance, data_o=17, ovf_o=0, err_o=0.
REQ-030 SHALL check banks_p=4, width_p=10: index=0x2A, bank=3 -> v_o=1 one cycle after acceptance, data_o=171.
REQ-031 SHALL check banks_p=3, width_p=8: index=100, bank=2 -> data_o=46, ovf_o=1.
REQ-032 SHALL check banks_p=3: bank=3 -> v_o=1 next cycle, err_o=1, data_o=0.
REQ-033 SHALL check backpressure: yumi_i held 0 for 5 cycles -> outputs stable, ready_o=0, new v_i ignored; yumi_i=1 -> ready_o=1 next cycle.
REQ-034 SHALL check reset_n_i pulsed low mid-CALC -> v_o never asserts for that request, ready_o=1 immediately, next request gives correct result.
